// File: rtl/apb_bridge_controller.sv
// rtl/apb_bridge_controller.sv - AHB-slave-side control FSM of the AHB-to-APB bridge
//
// Accepts single AHB transfers into a 256 MB APB region split across four
// 64 MB slaves, and sequences each one through APB SETUP and ENABLE while
// stalling the AHB master through HREADYout.
//
// Ports:
//   HCLK, HRESETn        clock, asynchronous active-low reset
//   HADDR, HTRANS,       AHB address phase
//   HWRITE, HREADYin
//   HWDATA               AHB write data (data phase)
//   PRDATA_TEMP          APB read data returned from APB_interface
//   HREADYout            0 = stall the master
//   HRDATA, HRESP        AHB read data / response (always OKAY)
//   PADDR_TEMP,          registered APB address, write data, direction
//   PWDATA_TEMP,
//   PWRITE_TEMP
//   PSELX_TEMP           one-hot APB slave select
//   PENABLE_TEMP         APB enable
module apb_bridge_controller #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [31:0] HWDATA,
    input  logic        HREADYin,
    input  logic [31:0] PRDATA_TEMP,
    output logic        HREADYout,
    output logic [31:0] HRDATA,
    output logic [1:0]  HRESP,
    output logic [31:0] PADDR_TEMP,
    output logic [31:0] PWDATA_TEMP,
    output logic        PWRITE_TEMP,
    output logic [3:0]  PSELX_TEMP,
    output logic        PENABLE_TEMP
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WWAIT,
        ST_WRITE,
        ST_WENABLE,
        ST_READ,
        ST_RENABLE
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [1:0]  sel_idx;
    logic        in_region;
    logic        valid;
    logic        accept;

    assign in_region = (HADDR >= BASE_ADDR) && (HADDR <= BASE_ADDR + 32'h0FFF_FFFF);
    assign valid     = HREADYin && (HTRANS == 2'b10 || HTRANS == 2'b11) && in_region;

    // A new address phase is only sampled when no APB access is mid-flight.
    assign accept = (state == ST_IDLE) || (state == ST_RENABLE) || (state == ST_WENABLE);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_RENABLE, ST_WENABLE: begin
                if (valid) begin
                    state_next = HWRITE ? ST_WWAIT : ST_READ;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_WWAIT: state_next = ST_WRITE;
            ST_WRITE: state_next = ST_WENABLE;
            ST_READ:  state_next = ST_RENABLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Address-side registers only move on an accepted transfer, so they hold
    // their last values through idle periods.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            PADDR_TEMP  <= 32'h0;
            PWRITE_TEMP <= 1'b0;
            PWDATA_TEMP <= 32'h0;
            sel_idx     <= 2'd0;
        end else begin
            if (accept && valid) begin
                PADDR_TEMP  <= HADDR;
                PWRITE_TEMP <= HWRITE;
                sel_idx     <= HADDR[27:26];
            end
            // HWDATA is only valid in the AHB data phase, which is WWAIT.
            if (state == ST_WWAIT) begin
                PWDATA_TEMP <= HWDATA;
            end
        end
    end

    // Outputs decode straight from the state register so that an asynchronous
    // reset drops select/enable and releases the master immediately.
    always_comb begin
        PSELX_TEMP   = 4'b0000;
        PENABLE_TEMP = 1'b0;
        HREADYout    = 1'b1;
        HRDATA       = 32'h0;
        case (state)
            ST_WWAIT: begin
                HREADYout = 1'b0;
            end
            ST_WRITE, ST_READ: begin
                PSELX_TEMP = 4'b0001 << sel_idx;
                HREADYout  = 1'b0;
            end
            ST_WENABLE: begin
                PSELX_TEMP   = 4'b0001 << sel_idx;
                PENABLE_TEMP = 1'b1;
            end
            ST_RENABLE: begin
                PSELX_TEMP   = 4'b0001 << sel_idx;
                PENABLE_TEMP = 1'b1;
                HRDATA       = PRDATA_TEMP;
            end
            default: begin
            end
        endcase
    end

    assign HRESP = 2'b00;

endmodule

// File: tb/tb_apb_bridge_controller.sv
// tb/tb_apb_bridge_controller.sv - self-checking bench for apb_bridge_controller
module tb_apb_bridge_controller;

    logic        HCLK;
    logic        HRESETn;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HREADYin;
    logic [31:0] PRDATA_TEMP;
    logic        HREADYout;
    logic [31:0] HRDATA;
    logic [1:0]  HRESP;
    logic [31:0] PADDR_TEMP;
    logic [31:0] PWDATA_TEMP;
    logic        PWRITE_TEMP;
    logic [3:0]  PSELX_TEMP;
    logic        PENABLE_TEMP;

    int errors = 0;
    int checks = 0;

    apb_bridge_controller dut (
        .HCLK         (HCLK),
        .HRESETn      (HRESETn),
        .HADDR        (HADDR),
        .HTRANS       (HTRANS),
        .HWRITE       (HWRITE),
        .HWDATA       (HWDATA),
        .HREADYin     (HREADYin),
        .PRDATA_TEMP  (PRDATA_TEMP),
        .HREADYout    (HREADYout),
        .HRDATA       (HRDATA),
        .HRESP        (HRESP),
        .PADDR_TEMP   (PADDR_TEMP),
        .PWDATA_TEMP  (PWDATA_TEMP),
        .PWRITE_TEMP  (PWRITE_TEMP),
        .PSELX_TEMP   (PSELX_TEMP),
        .PENABLE_TEMP (PENABLE_TEMP)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [1:0] tr, input logic [31:0] a, input logic w,
                         input logic [31:0] wd, input logic rdy, input logic [31:0] rd);
        HTRANS = tr; HADDR = a; HWRITE = w; HWDATA = wd; HREADYin = rdy; PRDATA_TEMP = rd;
    endtask

    // Directed vectors: inputs held across one rising edge, outputs checked after it.
    typedef struct {
        logic [1:0]  tr;
        logic [31:0] a;
        logic        w;
        logic [31:0] wd;
        logic        rdy;
        logic [31:0] rd;
        logic [3:0]  e_sel;
        logic        e_pen;
        logic        e_hrdy;
        logic [31:0] e_hrdata;
        logic [31:0] e_paddr;
        logic        e_pwrite;
        logic [31:0] e_pwdata;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [1:0] tr, input logic [31:0] a, input logic w,
                                input logic [31:0] wd, input logic rdy, input logic [31:0] rd,
                                input logic [3:0] s, input logic p, input logic h,
                                input logic [31:0] hd, input logic [31:0] pa,
                                input logic pw, input logic [31:0] pd);
        vec_t v;
        v.tr = tr; v.a = a; v.w = w; v.wd = wd; v.rdy = rdy; v.rd = rd;
        v.e_sel = s; v.e_pen = p; v.e_hrdy = h; v.e_hrdata = hd;
        v.e_paddr = pa; v.e_pwrite = pw; v.e_pwdata = pd;
        return v;
    endfunction

    // Transaction-level reference: an accepted transfer expands into the list of
    // bus phases it will occupy; one phase is consumed per clock.
    typedef struct {
        logic [3:0] sel;
        logic       pen;
        logic       hrdy;
        logic       rd_en;
        logic       data_phase;
    } phase_t;

    phase_t      mq[$];
    logic [31:0] m_paddr, m_pwdata;
    logic        m_pwrite;

    function automatic phase_t ph(input logic [3:0] s, input logic p, input logic h,
                                  input logic r, input logic d);
        phase_t x;
        x.sel = s; x.pen = p; x.hrdy = h; x.rd_en = r; x.data_phase = d;
        return x;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_paddr = 0; m_pwdata = 0; m_pwrite = 0;
    endtask

    task automatic model_edge();
        logic [3:0] oh;
        logic       v;
        v  = HREADYin && HTRANS >= 2 && HADDR >= 32'h8000_0000 && HADDR <= 32'h8FFF_FFFF;
        oh = 4'b0001 << HADDR[27:26];
        if (mq.size() <= 1) begin
            mq.delete();
            if (v) begin
                m_paddr  = HADDR;
                m_pwrite = HWRITE;
                if (HWRITE) begin
                    mq.push_back(ph(4'b0000, 1'b0, 1'b0, 1'b0, 1'b1));
                    mq.push_back(ph(oh, 1'b0, 1'b0, 1'b0, 1'b0));
                    mq.push_back(ph(oh, 1'b1, 1'b1, 1'b0, 1'b0));
                end else begin
                    mq.push_back(ph(oh, 1'b0, 1'b0, 1'b0, 1'b0));
                    mq.push_back(ph(oh, 1'b1, 1'b1, 1'b1, 1'b0));
                end
            end
        end else begin
            if (mq[0].data_phase) m_pwdata = HWDATA;
            void'(mq.pop_front());
        end
    endtask

    task automatic model_check();
        phase_t cur;
        cur = (mq.size() > 0) ? mq[0] : ph(4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("rnd_psel",   {28'h0, PSELX_TEMP},  {28'h0, cur.sel});
        chk("rnd_penable", {31'h0, PENABLE_TEMP}, {31'h0, cur.pen});
        chk("rnd_hready", {31'h0, HREADYout},   {31'h0, cur.hrdy});
        chk("rnd_hrdata", HRDATA, cur.rd_en ? PRDATA_TEMP : 32'h0);
        chk("rnd_paddr",  PADDR_TEMP, m_paddr);
        chk("rnd_pwrite", {31'h0, PWRITE_TEMP}, {31'h0, m_pwrite});
        chk("rnd_pwdata", PWDATA_TEMP, m_pwdata);
        chk("rnd_hresp",  {30'h0, HRESP}, 32'h0);
    endtask

    initial begin
        drive(2'd0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0);
        HRESETn = 1'b0;
        #12;
        chk("rst_psel",    {28'h0, PSELX_TEMP}, 32'h0);
        chk("rst_penable", {31'h0, PENABLE_TEMP}, 32'h0);
        chk("rst_hready",  {31'h0, HREADYout}, 32'h1);
        chk("rst_hrdata",  HRDATA, 32'h0);
        chk("rst_paddr",   PADDR_TEMP, 32'h0);
        chk("rst_pwdata",  PWDATA_TEMP, 32'h0);
        chk("rst_pwrite",  {31'h0, PWRITE_TEMP}, 32'h0);
        chk("rst_hresp",   {30'h0, HRESP}, 32'h0);
        @(negedge HCLK);
        HRESETn = 1'b1;

        //          tr  addr          w  hwdata        rdy prdata         sel      pen hrdy hrdata         paddr         pw pwdata
        vecs.push_back(mk(2, 32'h8400_0010, 0, 32'h0,        1, 32'hCAFE_0001, 4'b0010, 0, 0, 32'h0,         32'h8400_0010, 0, 32'h0));
        vecs.push_back(mk(0, 32'h0,         0, 32'h0,        1, 32'hCAFE_0001, 4'b0010, 1, 1, 32'hCAFE_0001, 32'h8400_0010, 0, 32'h0));
        vecs.push_back(mk(2, 32'h8800_0004, 1, 32'h0,        1, 32'h0,         4'b0000, 0, 0, 32'h0,         32'h8800_0004, 1, 32'h0));
        vecs.push_back(mk(0, 32'h0,         0, 32'hDEAD_BEEF, 1, 32'h0,        4'b0100, 0, 0, 32'h0,         32'h8800_0004, 1, 32'hDEAD_BEEF));
        vecs.push_back(mk(0, 32'h0,         0, 32'h0,        1, 32'h0,         4'b0100, 1, 1, 32'h0,         32'h8800_0004, 1, 32'hDEAD_BEEF));
        vecs.push_back(mk(2, 32'h8000_0000, 0, 32'h0,        1, 32'h0,         4'b0001, 0, 0, 32'h0,         32'h8000_0000, 0, 32'hDEAD_BEEF));
        vecs.push_back(mk(2, 32'h8C00_0008, 1, 32'h0,        1, 32'h1234_5678, 4'b0001, 1, 1, 32'h1234_5678, 32'h8000_0000, 0, 32'hDEAD_BEEF));
        vecs.push_back(mk(2, 32'h8C00_0008, 1, 32'h0,        1, 32'h0,         4'b0000, 0, 0, 32'h0,         32'h8C00_0008, 1, 32'hDEAD_BEEF));
        vecs.push_back(mk(0, 32'h0,         0, 32'h0BAD_F00D, 1, 32'h0,        4'b1000, 0, 0, 32'h0,         32'h8C00_0008, 1, 32'h0BAD_F00D));
        vecs.push_back(mk(0, 32'h0,         0, 32'h0,        1, 32'h0,         4'b1000, 1, 1, 32'h0,         32'h8C00_0008, 1, 32'h0BAD_F00D));
        vecs.push_back(mk(0, 32'h0,         0, 32'h0,        1, 32'h0,         4'b0000, 0, 1, 32'h0,         32'h8C00_0008, 1, 32'h0BAD_F00D));
        vecs.push_back(mk(2, 32'h7000_0000, 0, 32'h0,        1, 32'h0,         4'b0000, 0, 1, 32'h0,         32'h8C00_0008, 1, 32'h0BAD_F00D));
        vecs.push_back(mk(1, 32'h8000_0000, 0, 32'h0,        1, 32'h0,         4'b0000, 0, 1, 32'h0,         32'h8C00_0008, 1, 32'h0BAD_F00D));
        vecs.push_back(mk(2, 32'h9000_0000, 1, 32'h0,        1, 32'h0,         4'b0000, 0, 1, 32'h0,         32'h8C00_0008, 1, 32'h0BAD_F00D));
        vecs.push_back(mk(2, 32'h8000_0000, 0, 32'h0,        0, 32'h0,         4'b0000, 0, 1, 32'h0,         32'h8C00_0008, 1, 32'h0BAD_F00D));
        vecs.push_back(mk(3, 32'h8FFF_FFFC, 0, 32'h0,        1, 32'h0,         4'b1000, 0, 0, 32'h0,         32'h8FFF_FFFC, 0, 32'h0BAD_F00D));

        foreach (vecs[i]) begin
            drive(vecs[i].tr, vecs[i].a, vecs[i].w, vecs[i].wd, vecs[i].rdy, vecs[i].rd);
            @(posedge HCLK);
            #1;
            chk($sformatf("v%0d_psel", i),    {28'h0, PSELX_TEMP}, {28'h0, vecs[i].e_sel});
            chk($sformatf("v%0d_penable", i), {31'h0, PENABLE_TEMP}, {31'h0, vecs[i].e_pen});
            chk($sformatf("v%0d_hready", i),  {31'h0, HREADYout}, {31'h0, vecs[i].e_hrdy});
            chk($sformatf("v%0d_hrdata", i),  HRDATA, vecs[i].e_hrdata);
            chk($sformatf("v%0d_paddr", i),   PADDR_TEMP, vecs[i].e_paddr);
            chk($sformatf("v%0d_pwrite", i),  {31'h0, PWRITE_TEMP}, {31'h0, vecs[i].e_pwrite});
            chk($sformatf("v%0d_pwdata", i),  PWDATA_TEMP, vecs[i].e_pwdata);
            @(negedge HCLK);
        end

        // Reset asserted while a write sits in APB SETUP.
        drive(0, 32'h0, 0, 32'h0, 1, 32'h0);
        @(posedge HCLK); @(negedge HCLK);
        drive(2, 32'h8400_0000, 1, 32'h0, 1, 32'h0);
        @(posedge HCLK); @(negedge HCLK);
        drive(0, 32'h0, 0, 32'h5555_AAAA, 1, 32'h0);
        @(posedge HCLK); #1;
        chk("mid_setup_psel", {28'h0, PSELX_TEMP}, 32'h2);
        #2;
        HRESETn = 1'b0;
        #1;
        chk("mid_rst_psel",    {28'h0, PSELX_TEMP}, 32'h0);
        chk("mid_rst_penable", {31'h0, PENABLE_TEMP}, 32'h0);
        chk("mid_rst_hready",  {31'h0, HREADYout}, 32'h1);
        @(negedge HCLK);
        HRESETn = 1'b1;
        @(posedge HCLK); #1;
        chk("post_rst_penable", {31'h0, PENABLE_TEMP}, 32'h0);
        chk("post_rst_psel",    {28'h0, PSELX_TEMP}, 32'h0);
        chk("post_rst_hready",  {31'h0, HREADYout}, 32'h1);
        @(negedge HCLK);

        // Randomized traffic against the phase-list model.
        HRESETn = 1'b0;
        #1;
        model_reset();
        @(negedge HCLK);
        HRESETn = 1'b1;
        for (int n = 0; n < 600; n++) begin
            logic [31:0] a;
            case ($urandom_range(0, 5))
                0:       a = $urandom_range(0, 32'h7FFF_FFFF);
                1:       a = 32'h9000_0000 + $urandom_range(0, 32'h0FFF_FFFF);
                2:       a = 32'h8000_0000;
                3:       a = 32'h8FFF_FFFF;
                default: a = 32'h8000_0000 + $urandom_range(0, 32'h0FFF_FFFF);
            endcase
            drive(2'($urandom_range(0, 3)), a, 1'($urandom_range(0, 1)), $urandom,
                  ($urandom_range(0, 7) != 0), $urandom);
            @(posedge HCLK);
            model_edge();
            #1;
            model_check();
            @(negedge HCLK);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
